// File: rtl/csa_add_scheduler.sv
// csa_add_scheduler: time-shares one external 8-bit adder between two requesters.
// Operands are walked through the adder LSB-byte first with the carry chained in a
// register; arbitration is round-robin with one operation in flight at a time.
module csa_add_scheduler #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [8*NBYTES-1:0]   a0,
  input  logic [8*NBYTES-1:0]   b0,
  input  logic                  sub0,
  input  logic                  req1,
  input  logic [8*NBYTES-1:0]   a1,
  input  logic [8*NBYTES-1:0]   b1,
  input  logic                  sub1,
  output logic                  done0,
  output logic                  done1,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout_out,
  output logic                  ovf,
  output logic                  busy,
  output logic [7:0]            add_x,
  output logic [7:0]            add_y,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);

  localparam int unsigned IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                   state_q;
  logic [NBYTES-1:0][7:0]   a_q;
  logic [NBYTES-1:0][7:0]   b_q;       // already inverted for subtraction
  logic [NBYTES-1:0][7:0]   result_q;
  logic [IW-1:0]            idx_q;
  logic                     sub_q;
  logic                     carry_q;
  logic                     grant_q;   // requester currently being served
  logic                     last_grant_q;
  logic                     cout_q;
  logic                     ovf_q;
  logic                     done0_q;
  logic                     done1_q;

  logic                     gnt_sel;

  // Pick a requester: the sole asker, or on a tie the one not served last.
  always_comb begin
    gnt_sel = 1'b0;
    if (req0 && req1) begin
      gnt_sel = ~last_grant_q;
    end else begin
      gnt_sel = req1;
    end
  end

  // Present the current byte pair to the adder; idle outside RUN.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (state_q == StRun) begin
      add_x   = a_q[idx_q];
      add_y   = b_q[idx_q];
      add_cin = (idx_q == '0) ? sub_q : carry_q;
    end
  end

  // Sequencer FSM with registered results and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      idx_q        <= '0;
      sub_q        <= 1'b0;
      carry_q      <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            grant_q <= gnt_sel;
            if (gnt_sel) begin
              a_q   <= a1;
              b_q   <= sub1 ? ~b1 : b1;
              sub_q <= sub1;
            end else begin
              a_q   <= a0;
              b_q   <= sub0 ? ~b0 : b0;
              sub_q <= sub0;
            end
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          result_q[idx_q] <= add_sum;
          carry_q         <= add_cout;
          idx_q           <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            cout_q  <= add_cout;
            ovf_q   <= (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                       (add_sum[7] != a_q[NBYTES-1][7]);
            done0_q <= ~grant_q;
            done1_q <= grant_q;
            state_q <= StDone;
          end
        end
        StDone: begin
          last_grant_q <= grant_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result   = result_q;
  assign cout_out = cout_q;
  assign ovf      = ovf_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_csa_add_scheduler.sv
// Bench for csa_add_scheduler: table vectors, random operations against an
// arithmetic reference model, and hand sequences for arbitration and reset.
module tb_csa_add_scheduler;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, req1, sub0, sub1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           done0, done1, cout_out, ovf, busy;
  logic [W-1:0]   result;
  logic [7:0]     add_x, add_y, add_sum;
  logic           add_cin, add_cout;

  int errors = 0;
  int checks = 0;

  csa_add_scheduler #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .a0       (a0),
    .b0       (b0),
    .sub0     (sub0),
    .req1     (req1),
    .a1       (a1),
    .b1       (b1),
    .sub1     (sub1),
    .done0    (done0),
    .done1    (done1),
    .result   (result),
    .cout_out (cout_out),
    .ovf      (ovf),
    .busy     (busy),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // External 8-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_cin};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, signed range test, carries from partial sums.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic o,
                                output logic [NBYTES-1:0] cins);
    longint unsigned ua, ub, m;
    longint sa, sb, tr, lim;
    ua = a;
    ub = b;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    lim = longint'(1) <<< (W - 1);
    if (s) begin
      r  = a - b;
      c  = (ua >= ub);
      tr = sa - sb;
    end else begin
      r  = a + b;
      c  = ((ua + ub) >> W) != 0;
      tr = sa + sb;
    end
    o = (tr >= lim) || (tr < -lim);
    cins = '0;
    cins[0] = s;
    for (int k = 1; k < NBYTES; k++) begin
      m = (longint'(1) << (8 * k)) - 1;
      if (s) cins[k] = (ua & m) >= (ub & m);
      else   cins[k] = (((ua & m) + (ub & m)) >> (8 * k)) != 0;
    end
  endfunction

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Run one operation from IDLE on one requester and compare against expectations.
  task automatic run_op(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] er, input logic ec,
                        input logic eo, input logic [NBYTES-1:0] ecins, input string tag);
    int lat;
    logic [NBYTES-1:0] cins;
    logic other;
    lat   = -1;
    cins  = '0;
    other = 1'b0;
    if (who == 0) begin
      a0 = a; b0 = b; sub0 = s; req0 = 1'b1;
    end else begin
      a1 = a; b1 = b; sub1 = s; req1 = 1'b1;
    end
    for (int t = 1; t <= 20 && lat < 0; t++) begin
      tick();
      if (t == 1) begin
        // Operands only need to be valid in the grant cycle.
        a0 = $urandom; b0 = $urandom; sub0 = 1'($urandom);
        a1 = $urandom; b1 = $urandom; sub1 = 1'($urandom);
      end
      if (t <= NBYTES) cins[t-1] = add_cin;
      if ((who == 0) ? done1 : done0) other = 1'b1;
      if ((who == 0) ? done0 : done1) lat = t;
    end
    check({tag, " latency"}, 64'(lat), 64'(NBYTES + 1));
    check({tag, " result"}, result, er);
    check({tag, " cout"}, cout_out, ec);
    check({tag, " ovf"}, ovf, eo);
    check({tag, " cin seq"}, cins, ecins);
    check({tag, " other done"}, other, 1'b0);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check({tag, " done one cycle"}, {done0, done1, busy}, 3'b000);
  endtask

  typedef struct {
    int                 who;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic               s;
    logic [W-1:0]       er;
    logic               ec;
    logic               eo;
    logic [NBYTES-1:0]  ecins;
  } vec_t;

  initial begin
    vec_t vecs[6];
    logic [W-1:0] r;
    logic c, o;
    logic [NBYTES-1:0] ci;
    int who;
    logic [W-1:0] ra, rb;
    logic rs;
    int t0, t1, ndone, idle_cnt, last_t;
    int dwho[4];
    int dt[4];

    vecs[0] = '{0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 4'b0010};
    vecs[1] = '{1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 4'b0001};
    vecs[2] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 4'b1110};
    vecs[3] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4'b1110};
    vecs[4] = '{1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 4'b0001};
    vecs[5] = '{0, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 4'b1111};

    a0 = '0; b0 = '0; sub0 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;
    do_reset();

    check("reset busy/done", {busy, done0, done1}, 3'b000);
    check("reset result", result, '0);
    check("reset cout/ovf", {cout_out, ovf}, 2'b00);
    check("reset adder port", {add_x, add_y, add_cin}, 17'd0);

    // Directed vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].er, vecs[i].ec,
             vecs[i].eo, vecs[i].ecins, $sformatf("vec%0d", i));
    end

    // Random operations against the reference model.
    for (int i = 0; i < 20; i++) begin
      who = int'($urandom_range(1, 0));
      ra  = $urandom;
      rb  = $urandom;
      rs  = 1'($urandom);
      if (i % 5 == 0) ra = 32'h7FFF_FFFF;
      if (i % 7 == 0) rb = 32'h8000_0000;
      model(ra, rb, rs, r, c, o, ci);
      run_op(who, ra, rb, rs, r, c, o, ci, $sformatf("rnd%0d", i));
    end

    // Simultaneous first requests: requester 0 wins, then requester 1.
    do_reset();
    a0 = 32'h1111_1111; b0 = 32'h2222_2222; sub0 = 1'b0;
    a1 = 32'h0000_0050; b1 = 32'h0000_0030; sub1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    t0 = -1; t1 = -1;
    for (int t = 1; t <= 30 && (t0 < 0 || t1 < 0); t++) begin
      tick();
      if (done0) begin
        t0 = t;
        check("tie result0", result, 32'h3333_3333);
        req0 = 1'b0;
      end
      if (done1) begin
        t1 = t;
        check("tie result1", result, 32'h0000_0020);
        req1 = 1'b0;
      end
    end
    check("tie done0 time", 64'(t0), 64'd5);
    check("tie done1 time", 64'(t1), 64'd11);
    tick();

    // Reset in the second RUN cycle aborts silently.
    a0 = 32'h1234_5678; b0 = 32'h0101_0101; sub0 = 1'b0;
    req0 = 1'b1;
    tick();
    tick();
    rst  = 1'b1;
    req0 = 1'b0;
    tick();
    check("midrst busy", busy, 1'b0);
    check("midrst result", result, '0);
    check("midrst done", {done0, done1}, 2'b00);
    check("midrst cout/ovf", {cout_out, ovf}, 2'b00);
    rst = 1'b0;
    ndone = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (done0 || done1 || busy) ndone++;
    end
    check("midrst quiet", 64'(ndone), 64'd0);
    model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, r, c, o, ci);
    run_op(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, r, c, o, ci, "after_rst");

    // Both held continuously: strict alternation with one idle cycle between ops.
    do_reset();
    a0 = 32'h0000_1000; b0 = 32'h0000_0234; sub0 = 1'b0;
    a1 = 32'h0000_1000; b1 = 32'h0000_0234; sub1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    ndone = 0; idle_cnt = 0; last_t = 0;
    for (int t = 1; t <= 40 && ndone < 4; t++) begin
      tick();
      if (!busy) idle_cnt++;
      if (done0 || done1) begin
        dwho[ndone] = done1 ? 1 : 0;
        dt[ndone]   = t;
        check($sformatf("alt%0d order", ndone), 64'(dwho[ndone]), 64'(ndone % 2));
        check($sformatf("alt%0d result", ndone), result,
              (ndone % 2 == 0) ? 32'h0000_1234 : 32'h0000_0DCC);
        if (ndone > 0) begin
          check($sformatf("alt%0d spacing", ndone), 64'(dt[ndone] - last_t), 64'(NBYTES + 2));
          check($sformatf("alt%0d idle", ndone), 64'(idle_cnt), 64'd1);
        end
        last_t   = t;
        idle_cnt = 0;
        ndone++;
      end
    end
    check("alt count", 64'(ndone), 64'd4);
    req0 = 1'b0;
    req1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
